uart_rx_os: RTL and testbench

- Oversampled UART receiver for the HC-06 Bluetooth link: 8N1 at 9600 baud on a 25 MHz clock.
- Sits directly upstream of the motor command decoder. It turns the raw `rx` pin into a held byte plus a one-cycle valid strobe.
- Replaces delay-chain sampling with a single-clock-domain design: 2-FF synchronizer, 16x oversampling with 3-sample majority vote, start-bit validation, and framing/break detection.

---
 rtl/uart_rx_os.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampled 8N1 UART receiver, single clock domain.
//
// The raw line passes through a two-flop synchronizer. A free-running baud
// tick generator (CLK_HZ / (BAUD*OS)) paces the receive FSM. Each bit is
// decided by a 3-sample majority at oversample ticks 7, 8 and 9.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   rx        serial input line, idle high
//   rx_data   last correctly framed byte, held until the next good byte
//   rx_valid  one-clk pulse, rx_data updated this cycle
//   frame_err one-clk pulse, stop bit sampled low
//   break_det one-clk pulse with frame_err when data and stop were all zero
//   rx_busy   high whenever the FSM is not IDLE
module uart_rx_os #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 9600,
  parameter int OS     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       break_det,
  output logic       rx_busy
);

  localparam int DIV = (CLK_HZ + BAUD * OS / 2) / (BAUD * OS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          rx_p0, rx_p1, rx_s;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    os_cnt, os_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [1:0]    samp, samp_n;
  logic          maj, maj_r, maj_r_n;
  logic [7:0]    rx_data_n;
  logic          vld_n, ferr_n, brk_n;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p0/p1: metastability synchronizer, idles high like the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Oversample tick: free-running, never resynchronised to line edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_M1);

  // Third sample is taken live at os_cnt 9, so the vote is ready that tick
  assign maj = maj3(samp[1], samp[0], rx_s);

  always_comb begin
    state_n   = state;
    os_cnt_n  = os_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    samp_n    = samp;
    maj_r_n   = maj_r;
    rx_data_n = rx_data;
    vld_n     = 1'b0;
    ferr_n    = 1'b0;
    brk_n     = 1'b0;
    if (tick) begin
      if (state == START || state == DATA || state == STOP) begin
        os_cnt_n = os_cnt + 4'd1;
        if (os_cnt == 4'd7) samp_n[1] = rx_s;
        if (os_cnt == 4'd8) samp_n[0] = rx_s;
        if (os_cnt == 4'd9) maj_r_n   = maj;
      end
      case (state)
        WAIT_IDLE: if (rx_s) state_n = IDLE;
        IDLE: begin
          if (!rx_s) begin
            state_n  = START;
            os_cnt_n = 4'd0;
          end
        end
        START: begin
          if (os_cnt == 4'd9 && maj) begin
            state_n = IDLE;
          end else if (os_cnt == 4'd15) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
            os_cnt_n  = 4'd0;
          end
        end
        DATA: begin
          if (os_cnt == 4'd15) begin
            shift_n = {maj_r, shift[7:1]};
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_idx_n = bit_idx + 3'd1;
          end
        end
        STOP: begin
          // Decide mid-stop so a start edge right after it is not missed
          if (os_cnt == 4'd9) begin
            if (maj) begin
              rx_data_n = shift;
              vld_n     = 1'b1;
              state_n   = IDLE;
            end else begin
              ferr_n  = 1'b1;
              brk_n   = (shift == 8'h00);
              state_n = WAIT_IDLE;
            end
          end
        end
        default: state_n = WAIT_IDLE;
      endcase
    end
  end

  // Stage p2: FSM, datapath and registered output pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_IDLE;
      os_cnt    <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      samp      <= 2'b00;
      maj_r     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      samp      <= samp_n;
      maj_r     <= maj_r_n;
      rx_data   <= rx_data_n;
      rx_valid  <= vld_n;
      frame_err <= ferr_n;
      break_det <= brk_n;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// Bench for uart_rx_os. Runs the receiver at 156250 baud on 25 MHz
// (tick divider exactly 10) so the full scenario set fits a short run.
module tb_uart_rx_os;

  localparam int  CLK_HZ = 25000000;
  localparam int  BAUD   = 156250;
  localparam real BIT_NS = 1.0e9 / BAUD;
  localparam real CLK_NS = 40.0;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, break_det, rx_busy;

  always #20 clk = ~clk;

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .break_det (break_det),
    .rx_busy   (rx_busy)
  );

  // kind: 0 = rx_valid, 1 = frame_err, 2 = frame_err + break_det
  typedef struct {
    int         kind;
    logic [7:0] data;
    realtime    t0;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $realtime);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.t0   = $realtime;
    exp_q.push_back(e);
  endtask

  // Start bit, 8 data bits LSB first, then the stop level held for stop_bits.
  task automatic send_frame(input logic [7:0] b, input real bit_ns,
                            input logic stop_val, input real stop_bits);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(stop_bits * bit_ns);
  endtask

  task automatic send_good(input logic [7:0] b, input real bit_ns);
    push(0, b);
    last_good = b;
    send_frame(b, bit_ns, 1'b1, 1.0);
  endtask

  // Monitor: pops an expectation for every output pulse
  int      mon_kind;
  exp_t    mon_e;
  realtime mon_lat;

  always @(negedge clk) begin
    if (!reset && (rx_valid || frame_err || break_det)) begin
      if (rx_valid) mon_kind = (frame_err || break_det) ? 3 : 0;
      else          mon_kind = frame_err ? (break_det ? 2 : 1) : 3;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kind %0d rx_data 0x%02h, expected no event at %0t",
                 mon_kind, rx_data, $realtime);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
        check("event_data", 32'(rx_data), 32'(mon_e.data));
        mon_lat = $realtime - mon_e.t0;
        check("event_latency_in_window",
              32'((mon_lat >= 9.5 * BIT_NS) && (mon_lat <= 9.8 * BIT_NS)), 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    #(5 * CLK_NS + 3);
    check("reset_rx_data",   32'(rx_data),   32'h00);
    check("reset_rx_valid",  32'(rx_valid),  32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_break_det", 32'(break_det), 32'd0);
    check("reset_rx_busy",   32'(rx_busy),   32'd1);
    reset = 1'b0;
    #(10 * BIT_NS);
    check("idle_rx_busy", 32'(rx_busy), 32'd0);

    // 1: single byte
    fork
      send_good(8'h41, BIT_NS);
      begin
        #(5 * BIT_NS);
        check("t1_busy_mid_frame", 32'(rx_busy), 32'd1);
      end
    join
    #(BIT_NS);
    check("t1_rx_data", 32'(rx_data), 32'h41);
    check("t1_busy_after", 32'(rx_busy), 32'd0);

    // 2: back-to-back frames, no idle gap
    send_good(8'h41, BIT_NS);
    send_good(8'h42, BIT_NS);
    send_good(8'h43, BIT_NS);
    #(BIT_NS);
    check("t2_rx_data", 32'(rx_data), 32'h43);

    // 3: short low glitch is rejected as a false start
    #(2 * BIT_NS);
    rx = 1'b0;
    #(32 * CLK_NS);
    rx = 1'b1;
    #(28 * CLK_NS);
    check("t3_busy_during_glitch", 32'(rx_busy), 32'd1);
    #(120 * CLK_NS);
    check("t3_busy_after_glitch", 32'(rx_busy), 32'd0);
    #(2 * BIT_NS);
    send_good(8'h44, BIT_NS);
    #(BIT_NS);
    check("t3_rx_data", 32'(rx_data), 32'h44);

    // 4: stop bit held low for two bit times
    push(1, last_good);
    send_frame(8'h55, BIT_NS, 1'b0, 2.0);
    check("t4_busy_line_low", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("t4_busy_line_high", 32'(rx_busy), 32'd0);
    check("t4_rx_data_held", 32'(rx_data), 32'h44);

    // 5: long break
    push(2, last_good);
    rx = 1'b0;
    #(30 * BIT_NS);
    check("t5_busy_in_break", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    #(2 * BIT_NS);
    send_good(8'h47, BIT_NS);
    #(BIT_NS);
    check("t5_rx_data", 32'(rx_data), 32'h47);

    // 6: reset during data bit 4 of 0x41, released with the line low
    #(2 * BIT_NS);
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(BIT_NS);
    rx = 1'b0;
    #(3 * BIT_NS);
    rx = 1'b0;
    #(0.3 * BIT_NS);
    reset = 1'b1;
    last_good = 8'h00;
    #(5 * CLK_NS);
    check("t6_reset_rx_data",   32'(rx_data),   32'h00);
    check("t6_reset_rx_valid",  32'(rx_valid),  32'd0);
    check("t6_reset_frame_err", 32'(frame_err), 32'd0);
    check("t6_reset_break_det", 32'(break_det), 32'd0);
    check("t6_reset_rx_busy",   32'(rx_busy),   32'd1);
    #(0.2 * BIT_NS);
    reset = 1'b0;
    #(0.4 * BIT_NS);
    check("t6_busy_low_line", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    #(3 * BIT_NS);
    check("t6_busy_idle", 32'(rx_busy), 32'd0);
    check("t6_rx_data_cleared", 32'(rx_data), 32'h00);
    send_good(8'h42, BIT_NS / 1.02);
    #(2 * BIT_NS);
    check("t6_fast_rx_data", 32'(rx_data), 32'h42);
    send_good(8'h43, BIT_NS / 0.98);
    #(2 * BIT_NS);
    check("t6_slow_rx_data", 32'(rx_data), 32'h43);

    #(3 * BIT_NS);
    check("missing_events", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
